// File: rtl/matrix_stream_driver_if.sv
// Bus bundle between the stream driver, the source/result BRAMs and the multiply core.
// Signal names keep the driver's point of view (o_ = driven by the driver).
interface matrix_stream_driver_if #(
    parameter int unsigned IN_DATA_WITDH  = 8,
    parameter int unsigned SRC_ADDR_WIDTH = 7,
    parameter int unsigned RES_ADDR_WIDTH = 7
);
    logic [SRC_ADDR_WIDTH-1:0]  o_src_addr;
    logic [4*IN_DATA_WITDH-1:0] i_src_rdata;
    logic                       o_core_valid;
    logic [4*IN_DATA_WITDH-1:0] o_core_data;
    logic                       i_core_valid;
    logic [2*IN_DATA_WITDH-1:0] i_core_result0;
    logic [2*IN_DATA_WITDH-1:0] i_core_result1;
    logic                       o_res_we;
    logic [RES_ADDR_WIDTH-1:0]  o_res_addr;
    logic [4*IN_DATA_WITDH-1:0] o_res_wdata;

    modport master (
        output o_src_addr,
        input  i_src_rdata,
        output o_core_valid,
        output o_core_data,
        input  i_core_valid,
        input  i_core_result0,
        input  i_core_result1,
        output o_res_we,
        output o_res_addr,
        output o_res_wdata
    );

    modport slave (
        input  o_src_addr,
        output i_src_rdata,
        input  o_core_valid,
        input  o_core_data,
        output i_core_valid,
        output i_core_result0,
        output i_core_result1,
        input  o_res_we,
        input  o_res_addr,
        input  o_res_wdata
    );
endinterface

// File: rtl/matrix_stream_driver.sv
// Streams A then B from a source BRAM into the block-matrix multiply core, waits out the
// core's fixed compute time, then drains the results pairwise into a result BRAM.
module matrix_stream_driver #(
    parameter int unsigned IN_DATA_WITDH  = 8,
    parameter int unsigned BLOCK_SIZE     = 16,
    parameter int unsigned SRC_ADDR_WIDTH = 7,
    parameter int unsigned RES_ADDR_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    matrix_stream_driver_if.master  bus
);

    localparam int unsigned MAT_WORDS   = BLOCK_SIZE * BLOCK_SIZE / 4;
    localparam int unsigned CALC_CYCLES = BLOCK_SIZE ** 3;
    localparam int unsigned RES_WORDS   = BLOCK_SIZE * BLOCK_SIZE / 2;
    localparam int unsigned CNT_WIDTH   = $clog2(CALC_CYCLES) + 1;

    localparam logic [CNT_WIDTH-1:0] FetchLast = CNT_WIDTH'(2 * MAT_WORDS);
    localparam logic [CNT_WIDTH-1:0] CalcLast  = CNT_WIDTH'(CALC_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ResBeats  = CNT_WIDTH'(RES_WORDS);
    localparam logic [CNT_WIDTH-1:0] DrainLast = CNT_WIDTH'(RES_WORDS + 1);

    typedef enum logic [2:0] {StIdle, StFetch, StWaitCalc, StDrain, StDone} state_e;

    state_e                     state_q, state_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic                       res_we_q, res_we_d;
    logic [RES_ADDR_WIDTH-1:0]  res_addr_q, res_addr_d;
    logic [4*IN_DATA_WITDH-1:0] res_wdata_q, res_wdata_d;

    logic fetch_beat;
    logic drain_beat;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            res_we_q    <= 1'b0;
            res_addr_q  <= '0;
            res_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            res_we_q    <= res_we_d;
            res_addr_q  <= res_addr_d;
            res_wdata_q <= res_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_WIDTH'(1);
        err_d       = err_q;
        res_we_d    = 1'b0;
        res_addr_d  = res_addr_q;
        res_wdata_d = res_wdata_q;

        unique case (state_q)
            StIdle: begin
                cnt_d       = '0;
                res_addr_d  = '0;
                res_wdata_d = '0;
                if (i_start) begin
                    state_d = StFetch;
                    err_d   = 1'b0;
                end
            end
            StFetch: begin
                // Addresses run for 2*MAT_WORDS cycles; one extra cycle covers BRAM latency.
                if (cnt_q == FetchLast) begin
                    state_d = StWaitCalc;
                    cnt_d   = '0;
                end
            end
            StWaitCalc: begin
                if (cnt_q == CalcLast) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                // Core answers one cycle behind each drain beat; capture beat index is cnt-1.
                if (cnt_q != '0 && cnt_q <= ResBeats) begin
                    res_we_d    = 1'b1;
                    res_addr_d  = RES_ADDR_WIDTH'(cnt_q - CNT_WIDTH'(1));
                    res_wdata_d = {bus.i_core_result1, bus.i_core_result0};
                    // The core drops valid on its final beat, so that one is not checked.
                    if (cnt_q != ResBeats && !bus.i_core_valid) begin
                        err_d = 1'b1;
                    end
                end
                if (cnt_q == DrainLast) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign fetch_beat = (state_q == StFetch) && (cnt_q != '0);
    assign drain_beat = (state_q == StDrain) && (cnt_q < ResBeats);

    assign o_busy = (state_q == StFetch) || (state_q == StWaitCalc) || (state_q == StDrain);
    assign o_done = (state_q == StDone);
    assign o_err  = err_q;

    assign bus.o_src_addr   = (state_q == StFetch && cnt_q < FetchLast) ?
                              SRC_ADDR_WIDTH'(cnt_q) : '0;
    assign bus.o_core_valid = fetch_beat || drain_beat;
    assign bus.o_core_data  = fetch_beat ? bus.i_src_rdata : '0;
    assign bus.o_res_we     = res_we_q;
    assign bus.o_res_addr   = res_addr_q;
    assign bus.o_res_wdata  = res_wdata_q;

endmodule

// File: doc/matrix_stream_driver.md
Name: matrix_stream_driver

Overview:
- Initiator for the block-matrix multiply core's streaming interface.
- On a start pulse, reads A then B (row-major, 4 elements per 32-bit word) from a source BRAM and streams them to the core back-to-back.
- Waits the core's fixed compute time, then drives the core's readout, packing each two-element result beat into a result BRAM.
- Sits between the BRAM data mover and the multiply core.

Parameters:
- IN_DATA_WITDH, 8: element width; core data word is 4*IN_DATA_WITDH, result element is 2*IN_DATA_WITDH.
- BLOCK_SIZE, 16: n of the n x n block. Must be a power of 2 and at least 4.
- SRC_ADDR_WIDTH, 7: source BRAM word-address width; must hold 2*BLOCK_SIZE^2/4 words.
- RES_ADDR_WIDTH, 7: result BRAM word-address width; must hold BLOCK_SIZE^2/2 words.
- Derived (localparam):
  - MAT_WORDS = BLOCK_SIZE^2/4 (64)
  - CALC_CYCLES = BLOCK_SIZE^3 (4096)
  - RES_WORDS = BLOCK_SIZE^2/2 (128)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- i_start  in  1  start pulse; sampled only in IDLE
- o_busy  out  1  high from the cycle after start acceptance until o_done
- o_done  out  1  one-cycle pulse after the last result write
- o_err  out  1  sticky; set if core valid was missing on an expected beat; cleared on next start
- o_src_addr  out  SRC_ADDR_WIDTH  source read address; A at 0..MAT_WORDS-1, B at MAT_WORDS..2*MAT_WORDS-1
- i_src_rdata  in  4*IN_DATA_WITDH  source read data, valid 1 cycle after address
- o_core_valid  out  1  drives the core's i_valid
- o_core_data  out  4*IN_DATA_WITDH  drives the core's data; byte k = element column j+k
- i_core_valid  in  1  core o_valid
- i_core_result0  in  2*IN_DATA_WITDH  core C[i][j]
- i_core_result1  in  2*IN_DATA_WITDH  core C[i][j+1]
- o_res_we  out  1  result BRAM write enable
- o_res_addr  out  RES_ADDR_WIDTH  result word address 0..RES_WORDS-1
- o_res_wdata  out  4*IN_DATA_WITDH  {result1, result0}

Behaviour:
- Reset (reset_n low at a clock edge): all outputs 0, state IDLE, all counters 0.
  - Reset mid-operation aborts immediately; no further writes.
  - The core shares reset_n, so both ends restart together.
- States: IDLE -> FETCH -> WAIT_CALC -> DRAIN -> DONE -> IDLE.
- IDLE: i_start=1 in cycle S is accepted and clears o_err. i_start in any other state is ignored.
- FETCH:
  - o_src_addr = 0..2*MAT_WORDS-1 in cycles S+1..S+2*MAT_WORDS.
  - o_core_valid=1 with o_core_data=i_src_rdata in cycles S+2..S+2*MAT_WORDS+1.
  - Exactly 2*MAT_WORDS beats, contiguous with no gaps; the core's B phase does not honour valid, so a gap corrupts B.
  - o_core_data is 0 whenever o_core_valid=0.
  - Last B beat at T=S+2*MAT_WORDS+1.
- WAIT_CALC: o_core_valid=0 for cycles T+1..T+CALC_CYCLES (4096); cycle counter width is log2(CALC_CYCLES)+1.
- DRAIN:
  - o_core_valid=1 for exactly RES_WORDS cycles, T+CALC_CYCLES+1..T+CALC_CYCLES+RES_WORDS.
  - o_core_data=0 throughout.
- Capture window: the RES_WORDS cycles starting one cycle after the first drain beat.
  - Each cycle, register {i_core_result1,i_core_result0} into o_res_wdata, with o_res_we=1 and o_res_addr=beat index the following cycle.
  - Writes go to addresses 0..RES_WORDS-1 in order.
- Last beat: the core deasserts valid on its final result beat. The driver writes that beat unconditionally and does not check i_core_valid for it.
  - For beats 0..RES_WORDS-2, i_core_valid=0 sets o_err; the beat is still written.
- DONE: o_done=1 for one cycle after the last write, o_busy drops in the same cycle, then IDLE.
  - The next start can be accepted the cycle after DONE.
- No arithmetic is performed on results: pass-through packing only, no width change.
- Address counters never wrap mid-operation; they return to 0 at IDLE.

Test Plan:
- A=identity, B[i][j]=(16i+j)&0xFF, start at cycle S -> result word w = {B elem 2w+1, B elem 2w} zero-extended to 16 bits each; word 0 = 0x00010000, word 127 = 0x00FF00FE; o_done exactly at S+4356.
- A and B all 0xFF -> every o_res_wdata = 0xE010E010 (16*0xFE01 truncated), 128 writes, o_err=0.
- Beat-timing check -> o_core_valid high for 128 consecutive cycles S+2..S+129, low 4096 cycles, high 128 cycles S+4226..S+4353; o_res_we high S+4228..S+4355.
- i_start pulsed during FETCH, WAIT_CALC and DRAIN -> ignored, single o_done, counts unchanged.
- reset_n low at S+3000 for one cycle -> all outputs 0 next cycle, no writes; a restart then produces correct results.
- Stub core forcing i_core_valid=0 on beat 40 -> o_err=1 sticky through o_done, 128 writes still issued; next start clears o_err.
